// File: rtl/coord_stack.sv
// coord_stack: parametrised LIFO of (x, y) coordinate pairs.
//
// Features:
//   - Registered pop output (xOut/yOut) with a one-cycle outValid strobe.
//   - Status outputs empty/full/count are decoded from the stack pointer.
//   - A simultaneous push and pop replaces the top entry. On an empty
//     stack the pair passes straight through to the output instead.
//   - Overflow and underflow requests are ignored and reported on fail.
//
// Build option:
//   COORD_STACK_STICKY_FAIL_EN
//     defined   : fail is set by the first rejected request and held until rst.
//     undefined : fail pulses for one cycle after each rejected request.
//
// The storage array is not reset. Only the pointer and the output
// registers are reset.

module coord_stack #(
    parameter int COORD_W = 4,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [COORD_W-1:0] xIn,
    input  logic [COORD_W-1:0] yIn,
    output logic [COORD_W-1:0] xOut,
    output logic [COORD_W-1:0] yOut,
    output logic               outValid,
    output logic               empty,
    output logic               full,
    output logic [CNT_W-1:0]   count,
    output logic               fail
);

    localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               PW      = 2 * COORD_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Exactly one of these actions is applied at each edge.
    typedef enum logic [2:0] {
        ACT_IDLE    = 3'd0,
        ACT_PUSH    = 3'd1,
        ACT_POP     = 3'd2,
        ACT_REPLACE = 3'd3,
        ACT_PASS    = 3'd4,
        ACT_OVF     = 3'd5,
        ACT_UNF     = 3'd6
    } action_e;

    logic [PW-1:0]    r_mem [DEPTH];
    logic [CNT_W-1:0] r_sp;
    logic [PW-1:0]    r_out;
    logic             r_valid;
    logic             r_fail;

    action_e          w_act;
    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_top_idx;
    logic [PW-1:0]    w_in_pair;
    logic [PW-1:0]    w_top_pair;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_idx;
    logic             w_reject;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == DEPTH_C);
    assign w_in_pair = {xIn, yIn};

    // The write index is only used when the stack is not full, so it always
    // fits in AW bits. The top index is forced to 0 when the stack is empty,
    // which keeps the read inside the array.
    assign w_wr_idx  = AW'(r_sp);
    assign w_top_idx = w_empty ? '0 : AW'(r_sp - CNT_W'(1));
    assign w_top_pair = r_mem[w_top_idx];

    // Decode the request pair and the current occupancy into one action.
    always_comb begin
        w_act = ACT_IDLE;
        case ({push, pop})
            2'b10:   w_act = w_full  ? ACT_OVF  : ACT_PUSH;
            2'b01:   w_act = w_empty ? ACT_UNF  : ACT_POP;
            2'b11:   w_act = w_empty ? ACT_PASS : ACT_REPLACE;
            default: w_act = ACT_IDLE;
        endcase
    end

    // Select the array write port: append at sp, or overwrite the top entry.
    always_comb begin
        w_mem_we  = 1'b0;
        w_mem_idx = w_wr_idx;
        case (w_act)
            ACT_PUSH: begin
                w_mem_we  = 1'b1;
                w_mem_idx = w_wr_idx;
            end
            ACT_REPLACE: begin
                w_mem_we  = 1'b1;
                w_mem_idx = w_top_idx;
            end
            default: begin
                w_mem_we  = 1'b0;
                w_mem_idx = w_wr_idx;
            end
        endcase
    end

    assign w_reject = (w_act == ACT_OVF) || (w_act == ACT_UNF);

    // Write to the storage array. The contents are not reset, and a reset
    // edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_idx] <= w_in_pair;
        end
    end

    // Update the stack pointer, the output pair and the valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp    <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (w_act)
                ACT_PUSH: begin
                    r_sp <= r_sp + CNT_W'(1);
                end
                ACT_POP: begin
                    r_out   <= w_top_pair;
                    r_sp    <= r_sp - CNT_W'(1);
                    r_valid <= 1'b1;
                end
                ACT_REPLACE: begin
                    r_out   <= w_top_pair;
                    r_valid <= 1'b1;
                end
                ACT_PASS: begin
                    r_out   <= w_in_pair;
                    r_valid <= 1'b1;
                end
                default: begin
                    r_sp <= r_sp;
                end
            endcase
        end
    end

`ifdef COORD_STACK_STICKY_FAIL_EN
    // Sticky fail: the first rejected request sets it, and only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail <= 1'b0;
        end else if (w_reject) begin
            r_fail <= 1'b1;
        end
    end
`else
    // Pulsed fail: high for one cycle after each rejected request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fail <= 1'b0;
        end else begin
            r_fail <= w_reject;
        end
    end
`endif

    assign xOut     = r_out[PW-1:COORD_W];
    assign yOut     = r_out[COORD_W-1:0];
    assign outValid = r_valid;
    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_sp;
    assign fail     = r_fail;

endmodule
